store_drain_unit: RTL and testbench

STORE_DRAIN_UNIT -- requirements
Module: store_drain_unit

---
 rtl/store_drain_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_store_drain_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_unit.sv
// -----------------------------------------------------------------------------
// store_drain_unit
//
// Drains committed stores from the head of the store queue into data memory,
// one at a time. A credit counter tracks stores retired by the ROB but not yet
// popped. A store is only taken from the queue when at least one credit is
// available.
//
// Each popped store is latched and then aligned to its byte lanes. A legal
// store becomes a memory write request that is held until it is acknowledged.
// An illegal store (misaligned half or word, or size 11) is dropped with a
// one-cycle error pulse. It still uses up its credit and its queue entry.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   commit_cnt        stores retired this cycle (0..2), adds credits
//   sq_valid/addr/    store queue head entry (data right-aligned,
//   data/size         size 00 byte / 01 half / 10 word / 11 illegal)
//   sq_pop            one-cycle pop of the queue head
//   mem_req/addr/     registered write request: word-aligned address,
//   wdata/wstrb       lane-positioned data and byte strobes
//   mem_ack           write complete (only honoured while waiting)
//   misalign_err      one-cycle pulse for a dropped illegal store
//   drain_idle        FSM idle and no outstanding credits
// -----------------------------------------------------------------------------
module store_drain_unit #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int CREDIT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            commit_cnt,
   input  logic                  sq_valid,
   input  logic [ADDR_WIDTH-1:0] sq_addr,
   input  logic [DATA_WIDTH-1:0] sq_data,
   input  logic [1:0]            sq_size,
   output logic                  sq_pop,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_ack,
   output logic                  misalign_err,
   output logic                  drain_idle
);

   localparam int LANE_W = DATA_WIDTH / 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;

   // Latched copy of the popped store
   logic [ADDR_WIDTH-1:0]   st_addr_q, st_addr_d;
   logic [DATA_WIDTH-1:0]   st_data_q, st_data_d;
   logic [1:0]              st_size_q, st_size_d;

   // Registered memory-side outputs
   logic                    mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]              mem_wstrb_q, mem_wstrb_d;
   logic                    misalign_q, misalign_d;

   logic                    credit_avail;
   logic                    take_head;
   logic                    st_legal;
   logic [3:0]              lane_strb;
   logic [DATA_WIDTH-1:0]   lane_data;

   // Gating uses the registered count, so a commit can be used from the next
   // cycle onward.
   assign credit_avail = (credits_q != '0);
   assign take_head    = (state_q == S_IDLE) && sq_valid && credit_avail;

   // ---------------------------------------------------------------------------
   // Credit counter: commits and the pop both apply in the same cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      credits_d = credits_q + CREDIT_WIDTH'(commit_cnt) - CREDIT_WIDTH'(sq_pop);
   end

   // ---------------------------------------------------------------------------
   // Legality check and lane placement of the latched store.
   // Narrow data is replicated across lanes; the strobes pick the live lanes.
   // ---------------------------------------------------------------------------
   always_comb begin
      st_legal  = 1'b0;
      lane_strb = 4'b0000;
      lane_data = '0;
      case (st_size_q)
         2'b00: begin
            st_legal  = 1'b1;
            lane_strb = 4'b0001 << st_addr_q[1:0];
            lane_data = {4{st_data_q[LANE_W-1:0]}};
         end
         2'b01: begin
            st_legal  = ~st_addr_q[0];
            lane_strb = 4'b0011 << st_addr_q[1:0];
            lane_data = {2{st_data_q[2*LANE_W-1:0]}};
         end
         2'b10: begin
            st_legal  = (st_addr_q[1:0] == 2'b00);
            lane_strb = 4'b1111;
            lane_data = st_data_q;
         end
         default: begin
            st_legal  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state. mem_ack is only looked at in WAIT.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (take_head) state_d = S_ISSUE;
         S_ISSUE: state_d = st_legal ? S_WAIT : S_IDLE;
         S_WAIT:  if (mem_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and register next-values.
   // The request is registered when leaving ISSUE, so it first appears in WAIT.
   // An ack in that same cycle ends it, which gives 3-cycle store spacing.
   // ---------------------------------------------------------------------------
   always_comb begin
      sq_pop      = 1'b0;
      st_addr_d   = st_addr_q;
      st_data_d   = st_data_q;
      st_size_d   = st_size_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      misalign_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (take_head) begin
               sq_pop    = 1'b1;
               st_addr_d = sq_addr;
               st_data_d = sq_data;
               st_size_d = sq_size;
            end
         end
         S_ISSUE: begin
            if (st_legal) begin
               mem_req_d   = 1'b1;
               mem_addr_d  = {st_addr_q[ADDR_WIDTH-1:2], 2'b00};
               mem_wdata_d = lane_data;
               mem_wstrb_d = lane_strb;
            end else begin
               misalign_d  = 1'b1;
            end
         end
         S_WAIT: begin
            // Payload stays as it is; only the request drops after the ack.
            if (mem_ack) mem_req_d = 1'b0;
         end
         default: begin
            mem_req_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and counter registers. Reset abandons any pending request.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q   <= '0;
         st_addr_q   <= '0;
         st_data_q   <= '0;
         st_size_q   <= 2'b00;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         misalign_q  <= 1'b0;
      end else begin
         credits_q   <= credits_d;
         st_addr_q   <= st_addr_d;
         st_data_q   <= st_data_d;
         st_size_q   <= st_size_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         misalign_q  <= misalign_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_wstrb    = mem_wstrb_q;
   assign misalign_err = misalign_q;
   assign drain_idle   = (state_q == S_IDLE) && (credits_q == '0);

endmodule

// File: tb/tb_store_drain_unit.sv
// -----------------------------------------------------------------------------
// tb_store_drain_unit
//
// Self-checking bench for store_drain_unit. It has four parts:
//   - reset checks
//   - a table of single-store vectors (legal and illegal sizes and alignments)
//   - hand-written sequences for credit gating, back-pressure with credit
//     arithmetic, and reset during WAIT
//   - a randomized run checked against a transaction-level reference model
// -----------------------------------------------------------------------------
module tb_store_drain_unit;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 5;
   localparam int RN = 60;

   logic          clk;
   logic          rst_n;
   logic [1:0]    commit_cnt;
   logic          sq_valid;
   logic [AW-1:0] sq_addr;
   logic [DW-1:0] sq_data;
   logic [1:0]    sq_size;
   logic          sq_pop;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_ack;
   logic          misalign_err;
   logic          drain_idle;

   store_drain_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .commit_cnt(commit_cnt),
      .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_data(sq_data), .sq_size(sq_size),
      .sq_pop(sq_pop), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .misalign_err(misalign_err),
      .drain_idle(drain_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        legal;
      logic [31:0] maddr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } st_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: what one store should do at memory, from size/alignment rules
   function automatic st_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_t e;
      e.addr  = a;
      e.data  = d;
      e.size  = s;
      e.maddr = a - (a % 4);
      e.legal = 1'b0;
      e.strb  = 4'h0;
      e.wdata = 32'h0;
      case (s)
         2'd0: begin
            e.legal = 1'b1;
            e.strb  = 4'(32'd1 << (a % 4));
            e.wdata = (d & 32'hFF) * 32'h01010101;
         end
         2'd1: begin
            e.legal = ((a % 2) == 0);
            e.strb  = 4'(32'd3 << (a % 4));
            e.wdata = (d & 32'hFFFF) * 32'h00010001;
         end
         2'd2: begin
            e.legal = ((a % 4) == 0);
            e.strb  = 4'hF;
            e.wdata = d;
         end
         default: e.legal = 1'b0;
      endcase
      return e;
   endfunction

   // Credit range monitor (overflow / underflow of the committed-store count)
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         int nxt;
         nxt = int'(dut.credits_q) + int'(commit_cnt) - int'(sq_pop);
         if (nxt < 0 || nxt > (2**CW - 1)) begin
            fails++;
            $display("FAIL credit_range: next credit %0d outside 0..%0d", nxt, 2**CW - 1);
         end
      end
   end

   task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      sq_addr = a;
      sq_data = d;
      sq_size = s;
   endtask

   // One store from commit to completion, with the ack in the first WAIT cycle
   task automatic run_vec(input st_t v, input int idx);
      set_store(v.addr, v.data, v.size);
      sq_valid = 1'b1;
      commit_cnt = 2'd1;
      #1 chk($sformatf("v%0d_no_pop_on_commit", idx), sq_pop, 1'b0);
      tick();
      commit_cnt = 2'd0;
      #1 chk($sformatf("v%0d_pop", idx), sq_pop, 1'b1);
      tick();
      #1 chk($sformatf("v%0d_single_pop", idx), sq_pop, 1'b0);
      chk($sformatf("v%0d_issue_no_req", idx), mem_req, 1'b0);
      sq_valid = 1'b0;
      tick();
      chk($sformatf("v%0d_req", idx), mem_req, v.legal);
      chk($sformatf("v%0d_err", idx), misalign_err, !v.legal);
      if (v.legal) begin
         chk($sformatf("v%0d_addr", idx), mem_addr, v.maddr);
         chk($sformatf("v%0d_strb", idx), mem_wstrb, v.strb);
         chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         chk($sformatf("v%0d_req_drop", idx), mem_req, 1'b0);
      end else begin
         tick();
         chk($sformatf("v%0d_err_one_cycle", idx), misalign_err, 1'b0);
         chk($sformatf("v%0d_no_req", idx), mem_req, 1'b0);
      end
      chk($sformatf("v%0d_drain_idle", idx), drain_idle, 1'b1);
   endtask

   st_t vecs[8];
   st_t stores[RN];
   st_t q[$];
   st_t cur;
   int  pops, reqs, head, commits, mcred, dly, commit;
   bit  req_active, expect_drop, done;
   logic [31:0] ra, rd;
   logic [1:0]  rs;

   initial begin
      vecs[0] = '{32'h1004, 32'hDEADBEEF, 2'b10, 1'b1, 32'h1004, 4'b1111, 32'hDEADBEEF};
      vecs[1] = '{32'h2003, 32'h000000A5, 2'b00, 1'b1, 32'h2000, 4'b1000, 32'hA5A5A5A5};
      vecs[2] = '{32'h3001, 32'h00001234, 2'b01, 1'b0, 32'h0,    4'b0000, 32'h0};
      vecs[3] = '{32'h4002, 32'h7777BEEF, 2'b01, 1'b1, 32'h4000, 4'b1100, 32'hBEEFBEEF};
      vecs[4] = '{32'h5001, 32'h123456C3, 2'b00, 1'b1, 32'h5000, 4'b0010, 32'hC3C3C3C3};
      vecs[5] = '{32'h6002, 32'hFFFF0000, 2'b10, 1'b0, 32'h0,    4'b0000, 32'h0};
      vecs[6] = '{32'h7000, 32'h11111111, 2'b11, 1'b0, 32'h0,    4'b0000, 32'h0};
      vecs[7] = '{32'h8000, 32'hCAFE0011, 2'b01, 1'b1, 32'h8000, 4'b0011, 32'h00110011};

      // ---- reset state, with activity on the inputs ----
      rst_n = 1'b0;
      commit_cnt = 2'd2;
      sq_valid = 1'b1;
      set_store(32'h1004, 32'h1, 2'b10);
      mem_ack = 1'b1;
      tick();
      tick();
      chk("rst_sq_pop", sq_pop, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", mem_wstrb, 4'h0);
      chk("rst_misalign", misalign_err, 1'b0);
      chk("rst_drain_idle", drain_idle, 1'b1);
      commit_cnt = 2'd0;
      mem_ack = 1'b0;
      rst_n = 1'b1;
      tick();
      #1 chk("post_rst_no_credit_pop", sq_pop, 1'b0);
      sq_valid = 1'b0;
      tick();

      // ---- table-driven single stores ----
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // ---- credit gating ----
      sq_valid = 1'b1;
      set_store(32'hC000, 32'h0BADF00D, 2'b10);
      for (int i = 0; i < 10; i++) begin
         #1 chk("gate_no_pop", sq_pop, 1'b0);
         chk("gate_no_req", mem_req, 1'b0);
         tick();
      end
      commit_cnt = 2'd1;
      tick();
      commit_cnt = 2'd0;
      pops = 0;
      reqs = 0;
      for (int i = 0; i < 8; i++) begin
         mem_ack = mem_req;
         #1;
         if (sq_pop) pops++;
         if (mem_req) reqs++;
         tick();
      end
      mem_ack = 1'b0;
      sq_valid = 1'b0;
      chk("gate_one_pop", pops, 1);
      chk("gate_one_req", reqs, 1);
      chk("gate_drain_idle", drain_idle, 1'b1);

      // ---- back-pressure + commit of 2 during a pop ----
      sq_valid = 1'b1;
      set_store(32'h9000, 32'h11112222, 2'b10);
      commit_cnt = 2'd1;
      tick();
      commit_cnt = 2'd2;
      #1 chk("bp_pop1", sq_pop, 1'b1);
      tick();
      commit_cnt = 2'd0;
      set_store(32'hA001, 32'h0000005A, 2'b00);
      #1 chk("bp_issue_no_pop", sq_pop, 1'b0);
      tick();
      chk("bp_req1", mem_req, 1'b1);
      for (int i = 0; i < 6; i++) begin
         if (i == 5) mem_ack = 1'b1;
         #1 chk("bp_wait_no_pop", sq_pop, 1'b0);
         chk("bp_hold_req", mem_req, 1'b1);
         chk("bp_hold_addr", mem_addr, 32'h9000);
         chk("bp_hold_strb", mem_wstrb, 4'hF);
         chk("bp_hold_wdata", mem_wdata, 32'h11112222);
         tick();
      end
      mem_ack = 1'b0;
      #1 chk("bp_pop2_after_ack", sq_pop, 1'b1);
      chk("bp_req_drop", mem_req, 1'b0);
      chk("bp_not_idle", drain_idle, 1'b0);
      tick();
      set_store(32'hB000, 32'h33334444, 2'b10);
      tick();
      chk("bp_req2_addr", mem_addr, 32'hA000);
      chk("bp_req2_strb", mem_wstrb, 4'b0010);
      chk("bp_req2_wdata", mem_wdata, 32'h5A5A5A5A);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1 chk("bp_pop3_net_plus1", sq_pop, 1'b1);
      tick();
      sq_valid = 1'b0;
      tick();
      chk("bp_req3_addr", mem_addr, 32'hB000);
      chk("bp_req3_wdata", mem_wdata, 32'h33334444);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("bp_credits_zero", drain_idle, 1'b1);

      // ---- reset during WAIT ----
      sq_valid = 1'b1;
      set_store(32'hD000, 32'h55667788, 2'b10);
      commit_cnt = 2'd1;
      tick();
      commit_cnt = 2'd0;
      #1 chk("rw_pop", sq_pop, 1'b1);
      tick();
      tick();
      chk("rw_req_before", mem_req, 1'b1);
      rst_n = 1'b0;
      #1 chk("rw_req_cleared", mem_req, 1'b0);
      chk("rw_addr_cleared", mem_addr, 32'h0);
      chk("rw_strb_cleared", mem_wstrb, 4'h0);
      chk("rw_idle", drain_idle, 1'b1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("rw_no_pop", sq_pop, 1'b0);
         chk("rw_no_req", mem_req, 1'b0);
         tick();
      end
      commit_cnt = 2'd1;
      tick();
      commit_cnt = 2'd0;
      #1 chk("rw_pop_after_commit", sq_pop, 1'b1);
      tick();
      sq_valid = 1'b0;
      tick();
      chk("rw_req_new", mem_req, 1'b1);
      chk("rw_addr_new", mem_addr, 32'hD000);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("rw_drain_idle", drain_idle, 1'b1);

      // ---- randomized run against the transaction model ----
      for (int i = 0; i < RN; i++) begin
         ra = $urandom;
         rd = $urandom;
         rs = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (rs == 2'd1) ra[0] = 1'b0;
            else if (rs == 2'd2) ra[1:0] = 2'b00;
         end
         stores[i] = model(ra, rd, rs);
      end
      head = 0; commits = 0; mcred = 0; dly = 0;
      req_active = 1'b0; expect_drop = 1'b0; done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         if (expect_drop) begin
            chk("rnd_req_drop", mem_req, 1'b0);
            expect_drop = 1'b0;
         end
         if (misalign_err) begin
            chk("rnd_err_expected", (q.size() > 0) && !q[0].legal, 1'b1);
            if (q.size() > 0) void'(q.pop_front());
         end
         if (mem_req && !req_active) begin
            chk("rnd_req_expected", (q.size() > 0) && q[0].legal, 1'b1);
            if (q.size() > 0) cur = q.pop_front();
            chk("rnd_addr", mem_addr, cur.maddr);
            chk("rnd_strb", mem_wstrb, cur.strb);
            chk("rnd_wdata", mem_wdata, cur.wdata);
            req_active = 1'b1;
            dly = $urandom_range(0, 3);
         end else if (req_active) begin
            chk("rnd_req_held", mem_req, 1'b1);
            chk("rnd_addr_held", mem_addr, cur.maddr);
            chk("rnd_wdata_held", mem_wdata, cur.wdata);
         end
         commit = $urandom_range(0, 2);
         if (commits + commit > RN) commit = RN - commits;
         if (mcred > 10) commit = 0;
         commit_cnt = 2'(commit);
         commits += commit;
         sq_valid = (head < RN);
         if (head < RN) set_store(stores[head].addr, stores[head].data, stores[head].size);
         if (req_active) begin
            mem_ack = 1'b0;
            if (dly == 0) begin
               mem_ack = 1'b1;
               req_active = 1'b0;
               expect_drop = 1'b1;
            end else begin
               dly--;
            end
         end else begin
            mem_ack = 1'($urandom_range(0, 1));
         end
         #1;
         if (sq_pop) begin
            chk("rnd_pop_has_credit", mcred > 0, 1'b1);
            if (head < RN) begin
               q.push_back(stores[head]);
               head++;
            end
         end
         mcred += commit - int'(sq_pop);
         tick();
         done = (head == RN) && (commits == RN) && (q.size() == 0) && !req_active;
      end
      commit_cnt = 2'd0;
      sq_valid = 1'b0;
      mem_ack = 1'b0;
      chk("rnd_completed_in_budget", done, 1'b1);
      chk("rnd_final_no_req", mem_req, 1'b0);
      chk("rnd_final_drain_idle", drain_idle, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
